// File: rtl/bomb_ctrl.sv
// bomb_ctrl: single-bomb lifecycle controller (place, fuse, blast, neighbour clear).
// Optional define BOMB_CTRL_REARM_EN holds a request made while a bomb is live until IDLE.
module bomb_ctrl #(
  parameter int NUM_ROW        = 11,
  parameter int NUM_COL        = 19,
  parameter int MAP_MEM_WIDTH  = 2,
  parameter int FUSE_CYCLES    = 100_000_000,
  parameter int EXPLODE_CYCLES = 50_000_000,
  localparam int ADDR_WIDTH    = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     place_req,
  input  logic [4:0]               player_row,
  input  logic [4:0]               player_col,
  output logic [ADDR_WIDTH-1:0]    map_rd_addr,
  input  logic [MAP_MEM_WIDTH-1:0] map_rd_data,
  output logic                     map_we,
  output logic [ADDR_WIDTH-1:0]    map_wr_addr,
  output logic [MAP_MEM_WIDTH-1:0] map_wr_data,
  output logic                     explode_signal,
  output logic [ADDR_WIDTH-1:0]    explosion_addr,
  output logic                     bomb_active
);

  localparam int CNT_MAX = (FUSE_CYCLES > EXPLODE_CYCLES) ? FUSE_CYCLES : EXPLODE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]         FUSE_LOAD    = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         EXPLODE_LOAD = CNT_W'(EXPLODE_CYCLES - 1);
  localparam logic [MAP_MEM_WIDTH-1:0] TILE_EMPTY   = '0;
  localparam logic [MAP_MEM_WIDTH-1:0] TILE_DESTR   = MAP_MEM_WIDTH'(2);
  localparam logic [MAP_MEM_WIDTH-1:0] TILE_BOMB    = MAP_MEM_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0]    COL_STEP     = ADDR_WIDTH'(NUM_COL);
  localparam logic [ADDR_WIDTH-1:0]    ONE_STEP     = ADDR_WIDTH'(1);
  localparam logic [4:0]               LAST_ROW     = 5'(NUM_ROW - 1);
  localparam logic [4:0]               LAST_COL     = 5'(NUM_COL - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FUSE,
    EXPLODE,
    CLEAR_RD,
    CLEAR_WR
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              k_q, k_d;
  logic [4:0]              bomb_row_q, bomb_row_d;
  logic [4:0]              bomb_col_q, bomb_col_d;
  logic [ADDR_WIDTH-1:0]   bomb_addr_q, bomb_addr_d;
  logic [ADDR_WIDTH-1:0]   expl_addr_q, expl_addr_d;
  logic                    explode_q, explode_d;
  logic                    active_q, active_d;

  logic [ADDR_WIDTH-1:0]   player_addr;
  logic [ADDR_WIDTH-1:0]   tgt_addr;
  logic                    tgt_oob;
  logic                    start_req;

`ifdef BOMB_CTRL_REARM_EN
  logic pending_q, pending_d;
  assign start_req = place_req | pending_q;
`else
  assign start_req = place_req;
`endif

  assign player_addr = ADDR_WIDTH'(player_row) * COL_STEP + ADDR_WIDTH'(player_col);

  // Clear target k: 0 centre, 1 up, 2 down, 3 left, 4 right.
  always_comb begin
    tgt_addr = bomb_addr_q;
    tgt_oob  = 1'b0;
    case (k_q)
      3'd1: begin
        tgt_addr = bomb_addr_q - COL_STEP;
        tgt_oob  = (bomb_row_q == '0);
      end
      3'd2: begin
        tgt_addr = bomb_addr_q + COL_STEP;
        tgt_oob  = (bomb_row_q == LAST_ROW);
      end
      3'd3: begin
        tgt_addr = bomb_addr_q - ONE_STEP;
        tgt_oob  = (bomb_col_q == '0);
      end
      3'd4: begin
        tgt_addr = bomb_addr_q + ONE_STEP;
        tgt_oob  = (bomb_col_q == LAST_COL);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    bomb_row_d  = bomb_row_q;
    bomb_col_d  = bomb_col_q;
    bomb_addr_d = bomb_addr_q;
    expl_addr_d = expl_addr_q;
    map_rd_addr = bomb_addr_q;
    map_we      = 1'b0;
    map_wr_addr = '0;
    map_wr_data = '0;

    // Write strobes are combinational so the bomb write lands in the CHECK cycle itself.
    case (state_q)
      IDLE: begin
        map_rd_addr = player_addr;
        if (start_req) begin
          bomb_row_d  = player_row;
          bomb_col_d  = player_col;
          bomb_addr_d = player_addr;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (map_rd_data == TILE_EMPTY) begin
          map_we      = 1'b1;
          map_wr_addr = bomb_addr_q;
          map_wr_data = TILE_BOMB;
          cnt_d       = FUSE_LOAD;
          state_d     = FUSE;
        end else begin
          state_d = IDLE;
        end
      end
      FUSE: begin
        if (cnt_q == '0) begin
          cnt_d       = EXPLODE_LOAD;
          expl_addr_d = bomb_addr_q;
          state_d     = EXPLODE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXPLODE: begin
        if (cnt_q == '0) begin
          k_d     = '0;
          state_d = CLEAR_RD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLEAR_RD: begin
        map_rd_addr = tgt_addr;
        if (!tgt_oob) begin
          state_d = CLEAR_WR;
        end else if (k_q == 3'd4) begin
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      CLEAR_WR: begin
        map_rd_addr = tgt_addr;
        if (k_q == '0 || map_rd_data == TILE_DESTR) begin
          map_we      = 1'b1;
          map_wr_addr = tgt_addr;
          map_wr_data = TILE_EMPTY;
        end
        if (k_q == 3'd4) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = CLEAR_RD;
        end
      end
      default: state_d = IDLE;
    endcase

    explode_d = (state_d == EXPLODE);
    active_d  = (state_d == FUSE) || (state_d == EXPLODE) ||
                (state_d == CLEAR_RD) || (state_d == CLEAR_WR);

`ifdef BOMB_CTRL_REARM_EN
    pending_d = pending_q;
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (place_req && state_q != CHECK) begin
      pending_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      bomb_row_q  <= '0;
      bomb_col_q  <= '0;
      bomb_addr_q <= '0;
      expl_addr_q <= '0;
      explode_q   <= 1'b0;
      active_q    <= 1'b0;
`ifdef BOMB_CTRL_REARM_EN
      pending_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      bomb_row_q  <= bomb_row_d;
      bomb_col_q  <= bomb_col_d;
      bomb_addr_q <= bomb_addr_d;
      expl_addr_q <= expl_addr_d;
      explode_q   <= explode_d;
      active_q    <= active_d;
`ifdef BOMB_CTRL_REARM_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign explode_signal = explode_q;
  assign explosion_addr = expl_addr_q;
  assign bomb_active    = active_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Self-checking bench for bomb_ctrl: vector table of placements plus reset and re-request sequences.
`timescale 1ns/1ps
module tb_bomb_ctrl;
  localparam int NR   = 11;
  localparam int NC   = 19;
  localparam int FUSE = 8;
  localparam int EXPL = 4;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          place_req = 1'b0;
  logic [4:0]    player_row = '0;
  logic [4:0]    player_col = '0;
  logic [AW-1:0] map_rd_addr, map_wr_addr, explosion_addr;
  logic [1:0]    map_rd_data, map_wr_data;
  logic          map_we, explode_signal, bomb_active;

  bomb_ctrl #(
    .NUM_ROW(NR), .NUM_COL(NC), .MAP_MEM_WIDTH(2),
    .FUSE_CYCLES(FUSE), .EXPLODE_CYCLES(EXPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .place_req(place_req),
    .player_row(player_row), .player_col(player_col),
    .map_rd_addr(map_rd_addr), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .explode_signal(explode_signal), .explosion_addr(explosion_addr),
    .bomb_active(bomb_active)
  );

  always #5 clk = ~clk;

  // Map memory: synchronous read, one-cycle latency; bench preloads via init_mem.
  logic [1:0] mem      [0:255];
  logic [1:0] init_mem [0:255];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (map_we) begin
      mem[map_wr_addr] <= map_wr_data;
    end
    map_rd_data <= mem[map_rd_addr];
  end

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
    logic [1:0] t_c, t_u, t_d, t_l, t_r;
    int         exp_clear;
    int         exp_writes;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] exp_q [$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic logic [7:0] taddr(input logic [4:0] r, input logic [4:0] c);
    return 8'(int'(r) * NC + int'(c));
  endfunction

  task automatic fill_bg();
    for (int i = 0; i < 256; i++) init_mem[i] = 2'd2;
  endtask

  task automatic set_tile(input logic [4:0] r, input logic [4:0] c,
                          input logic [1:0] tc, input logic [1:0] tu, input logic [1:0] td,
                          input logic [1:0] tl, input logic [1:0] tr);
    logic [7:0] a;
    a = taddr(r, c);
    init_mem[a] = tc;
    if (r != 0)      init_mem[a - 8'd19] = tu;
    if (r != NR - 1) init_mem[a + 8'd19] = td;
    if (c != 0)      init_mem[a - 8'd1]  = tl;
    if (c != NC - 1) init_mem[a + 8'd1]  = tr;
  endtask

  task automatic commit_map();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Expected write stream: bomb write, centre clear, then destroyable in-bounds neighbours.
  task automatic push_expect(input logic [4:0] r, input logic [4:0] c,
                             input logic [1:0] tc, input logic [1:0] tu, input logic [1:0] td,
                             input logic [1:0] tl, input logic [1:0] tr);
    logic [7:0] a;
    a = taddr(r, c);
    if (tc == 2'd0) begin
      exp_q.push_back({a, 2'd3});
      exp_q.push_back({a, 2'd0});
      if (r != 0 && tu == 2'd2)      exp_q.push_back({a - 8'd19, 2'd0});
      if (r != NR - 1 && td == 2'd2) exp_q.push_back({a + 8'd19, 2'd0});
      if (c != 0 && tl == 2'd2)      exp_q.push_back({a - 8'd1, 2'd0});
      if (c != NC - 1 && tr == 2'd2) exp_q.push_back({a + 8'd1, 2'd0});
    end
  endtask

  task automatic take_write();
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL write_unexpected: got addr %0d data %0d, want no write", map_wr_addr, map_wr_data);
    end else begin
      e = exp_q.pop_front();
      check("write_addr_data", int'({map_wr_addr, map_wr_data}), int'(e));
    end
  endtask

  task automatic place(input logic [4:0] r, input logic [4:0] c);
    @(negedge clk);
    player_row = r;
    player_col = c;
    place_req  = 1'b1;
    @(negedge clk);
    place_req  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] a;
    bit accept, finished;
    int n, writes, first_we, first_act, act, first_exp, exp_cnt, clear_cnt, addr_bad;
    a = taddr(v.row, v.col);
    accept = (v.t_c == 2'd0);
    writes = 0; first_we = 0; first_act = 0; act = 0;
    first_exp = 0; exp_cnt = 0; clear_cnt = 0; addr_bad = 0; finished = 1'b0;
    fill_bg();
    set_tile(v.row, v.col, v.t_c, v.t_u, v.t_d, v.t_l, v.t_r);
    commit_map();
    push_expect(v.row, v.col, v.t_c, v.t_u, v.t_d, v.t_l, v.t_r);
    place(v.row, v.col);
    n = 1;
    forever begin
      if (map_we) begin
        writes++;
        if (first_we == 0) first_we = n;
        take_write();
      end
      if (bomb_active) begin
        act++;
        if (first_act == 0) first_act = n;
      end
      if (explode_signal) begin
        exp_cnt++;
        if (first_exp == 0) first_exp = n;
        if (explosion_addr != a) addr_bad++;
      end else if (bomb_active && exp_cnt > 0) begin
        clear_cnt++;
      end
      if (accept ? (act > 0 && !bomb_active) : (n == 3)) begin
        finished = 1'b1;
        break;
      end
      if (n >= 200) break;
      @(negedge clk);
      n++;
    end
    check("finished_in_budget", int'(finished), 1);
    check("write_count", writes, v.exp_writes);
    check("queue_drained", exp_q.size(), 0);
    if (accept) begin
      check("bomb_write_cycle", first_we, 1);
      check("active_rise_cycle", first_act, 2);
      check("explode_start_cycle", first_exp, 2 + FUSE);
      check("explode_len", exp_cnt, EXPL);
      check("explosion_addr_bad_cycles", addr_bad, 0);
      check("clear_cycles", clear_cnt, v.exp_clear);
      check("active_cycles", act, FUSE + EXPL + v.exp_clear);
      check("explosion_addr_hold", int'(explosion_addr), int'(a));
    end else begin
      check("reject_active", act, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    int n, writes, act, idle1, w40, exp_cnt;
    bit seen;

    vecs[0] = '{row: 5'd5,  col: 5'd9,  t_c: 2'd0, t_u: 2'd2, t_d: 2'd0, t_l: 2'd0, t_r: 2'd0, exp_clear: 10, exp_writes: 3};
    vecs[1] = '{row: 5'd0,  col: 5'd0,  t_c: 2'd0, t_u: 2'd0, t_d: 2'd2, t_l: 2'd0, t_r: 2'd2, exp_clear: 8,  exp_writes: 4};
    vecs[2] = '{row: 5'd5,  col: 5'd9,  t_c: 2'd1, t_u: 2'd0, t_d: 2'd0, t_l: 2'd0, t_r: 2'd0, exp_clear: 0,  exp_writes: 0};
    vecs[3] = '{row: 5'd5,  col: 5'd9,  t_c: 2'd2, t_u: 2'd0, t_d: 2'd0, t_l: 2'd0, t_r: 2'd0, exp_clear: 0,  exp_writes: 0};
    vecs[4] = '{row: 5'd3,  col: 5'd4,  t_c: 2'd0, t_u: 2'd1, t_d: 2'd2, t_l: 2'd1, t_r: 2'd2, exp_clear: 10, exp_writes: 4};
    vecs[5] = '{row: 5'd10, col: 5'd18, t_c: 2'd0, t_u: 2'd2, t_d: 2'd0, t_l: 2'd2, t_r: 2'd0, exp_clear: 8,  exp_writes: 4};
    vecs[6] = '{row: 5'd0,  col: 5'd18, t_c: 2'd0, t_u: 2'd0, t_d: 2'd2, t_l: 2'd1, t_r: 2'd0, exp_clear: 8,  exp_writes: 3};
    vecs[7] = '{row: 5'd10, col: 5'd0,  t_c: 2'd0, t_u: 2'd2, t_d: 2'd0, t_l: 2'd0, t_r: 2'd2, exp_clear: 8,  exp_writes: 4};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_map_we", int'(map_we), 0);
    check("rst_wr_addr", int'(map_wr_addr), 0);
    check("rst_wr_data", int'(map_wr_data), 0);
    check("rst_explode", int'(explode_signal), 0);
    check("rst_expl_addr", int'(explosion_addr), 0);
    check("rst_active", int'(bomb_active), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset in the second explode cycle.
    fill_bg();
    set_tile(5'd5, 5'd9, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2);
    commit_map();
    exp_q.push_back({taddr(5'd5, 5'd9), 2'd3});
    place(5'd5, 5'd9);
    exp_cnt = 0;
    for (int c = 0; c < 40 && exp_cnt < 2; c++) begin
      if (map_we) take_write();
      if (explode_signal) exp_cnt++;
      if (exp_cnt < 2) @(negedge clk);
    end
    check("reached_explode_2", exp_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_explode", int'(explode_signal), 0);
    check("arst_active", int'(bomb_active), 0);
    check("arst_expl_addr", int'(explosion_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    act = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (map_we) begin writes++; take_write(); end
      if (bomb_active) act++;
    end
    check("post_rst_writes", writes, 0);
    check("post_rst_active", act, 0);
    check("bomb_tile_left", int'(mem[taddr(5'd5, 5'd9)]), 3);
    exp_q.delete();

    // Second request during the fuse.
    fill_bg();
    set_tile(5'd5, 5'd9, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    set_tile(5'd2, 5'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    commit_map();
    push_expect(5'd5, 5'd9, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
`ifdef BOMB_CTRL_REARM_EN
    push_expect(5'd2, 5'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
`endif
    place(5'd5, 5'd9);
    n = 1; writes = 0; act = 0; idle1 = 0; w40 = 0; seen = 1'b0;
    while (n <= 80) begin
      if (n == 3) begin
        player_row = 5'd2;
        player_col = 5'd2;
        place_req  = 1'b1;
      end
      if (n == 4) place_req = 1'b0;
      if (map_we) begin
        writes++;
        if (map_wr_addr == 8'd40 && map_wr_data == 2'd3) w40 = n;
        take_write();
      end
      if (bomb_active) begin
        act++;
        seen = 1'b1;
      end else if (seen && idle1 == 0) begin
        idle1 = n;
      end
      @(negedge clk);
      n++;
    end
    check("first_bomb_idle_cycle", idle1, 2 + FUSE + EXPL + 10);
    check("intrude_queue_drained", exp_q.size(), 0);
`ifdef BOMB_CTRL_REARM_EN
    check("rearm_writes", writes, 4);
    check("rearm_check_cycle", w40, idle1 + 1);
    check("rearm_active_cycles", act, 2 * (FUSE + EXPL + 10));
`else
    check("ignored_writes", writes, 2);
    check("ignored_active_cycles", act, FUSE + EXPL + 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
